// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared MIPS control-flow decode constants and PC generator defaults.
package pc_gen_pkg;

  // Primary opcodes (ir[31:26])
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;

  // SPECIAL function codes (ir[5:0])
  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;

  // REGIMM rt-field selectors (ir[20:16])
  localparam logic [4:0] RT_BLTZ    = 5'b00000;
  localparam logic [4:0] RT_BGEZ    = 5'b00001;

  // Default reset PC and exception vector
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VEC  = 32'h0000_4180;

  // Next-PC source selection
  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JUMP   = 2'd2,
    PC_JREG   = 2'd3
  } pc_src_e;

  // Sign-extended, word-scaled branch displacement
  function automatic logic [31:0] branch_disp(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/pc_gen_branch_cmp.sv
// branch_cmp: purely combinational condition evaluation for D-stage conditional branches.
// Jumps are not handled here; taken is 0 for any non-branch opcode.
module branch_cmp
  import pc_gen_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [4:0]  rt_fld,
  input  logic [31:0] rs_d,
  input  logic [31:0] rt_d,
  output logic        taken
);

  logic rs_zero;
  logic rs_neg;

  assign rs_zero = (rs_d == '0);
  assign rs_neg  = rs_d[31];

  // Evaluate the branch condition selected by opcode (and rt field for REGIMM)
  always_comb begin
    taken = 1'b0;
    unique case (op)
      OP_BEQ:  taken = (rs_d == rt_d);
      OP_BNE:  taken = (rs_d != rt_d);
      OP_BLEZ: taken = rs_neg | rs_zero;
      OP_BGTZ: taken = ~rs_neg & ~rs_zero;
      OP_REGIMM: begin
        if (rt_fld == RT_BLTZ)      taken = rs_neg;
        else if (rt_fld == RT_BGEZ) taken = ~rs_neg;
        else                        taken = 1'b0;
      end
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch-stage PC generator. Owns the PC register, decodes D-stage
// control flow, counts accepted redirects (saturating) and optionally
// provides an exception/eret path (define PC_EXC_EN).
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter int unsigned DELAY_SLOT = 1,
  parameter int unsigned CNT_W      = 16,
  parameter logic [31:0] EXC_VEC    = DEF_EXC_VEC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [31:0]      ir_d,
  input  logic [31:0]      pc4_d,
  input  logic [31:0]      rs_d,
  input  logic [31:0]      rt_d,
  output logic [31:0]      pc_f,
  output logic [31:0]      pc4_f,
  output logic             redirect,
  output logic             kill_f,
  output logic [CNT_W-1:0] redirect_cnt
`ifdef PC_EXC_EN
  ,
  input  logic             exc_req,
  input  logic [31:0]      exc_pc,
  input  logic             eret,
  output logic [31:0]      epc
`endif
);

  logic [5:0]  op;
  logic [4:0]  rt_fld;
  logic [5:0]  func;
  logic        br_taken;
  logic        is_jump;
  logic        is_jreg;
  pc_src_e     pc_src;
  logic [31:0] pc_d;
  logic [31:0] target;
  logic [31:0] npc;
  logic        exc_take;
  logic        eret_take;
  logic        accept;

  assign op     = ir_d[31:26];
  assign rt_fld = ir_d[20:16];
  assign func   = ir_d[5:0];
  assign pc_d   = pc4_d - 32'd4;

  branch_cmp u_branch_cmp (
    .op     (op),
    .rt_fld (rt_fld),
    .rs_d   (rs_d),
    .rt_d   (rt_d),
    .taken  (br_taken)
  );

  assign is_jump = (op == OP_J) || (op == OP_JAL);
  assign is_jreg = (op == OP_SPECIAL) && ((func == FN_JR) || (func == FN_JALR));

  // Pick the next-PC source for the D-stage instruction
  always_comb begin
    pc_src = PC_SEQ;
    if (is_jreg)       pc_src = PC_JREG;
    else if (is_jump)  pc_src = PC_JUMP;
    else if (br_taken) pc_src = PC_BRANCH;
  end

  // Form the redirect target; jump region comes from the D instr's own PC
  always_comb begin
    target = pc4_f;
    unique case (pc_src)
      PC_BRANCH: target = pc4_d + branch_disp(ir_d[15:0]);
      PC_JUMP:   target = {pc_d[31:28], ir_d[25:0], 2'b00};
      PC_JREG:   target = rs_d;
      default:   target = pc4_f;
    endcase
  end

  assign redirect = (pc_src != PC_SEQ);
  assign pc4_f    = pc_f + 32'd4;
  assign npc      = redirect ? target : pc4_f;

`ifdef PC_EXC_EN
  logic [31:0] epc_q;

  assign exc_take  = exc_req;
  assign eret_take = eret & ~exc_req;
  assign epc       = epc_q;

  // Exception PC capture; exc_req always wins over eret
  always_ff @(posedge clk) begin
    if (!reset)       epc_q <= '0;
    else if (exc_req) epc_q <= exc_pc;
  end
`else
  localparam logic [31:0] unused_exc_vec = EXC_VEC;

  assign exc_take  = 1'b0;
  assign eret_take = 1'b0;
`endif

  // A redirect only takes effect when nothing higher-priority steers the PC
  assign accept = redirect & ~stall & ~exc_take & ~eret_take;
  assign kill_f = (DELAY_SLOT == 0) ? accept : 1'b0;

  // PC register: reset > exception > eret > stall hold > next PC
  always_ff @(posedge clk) begin
    if (!reset)         pc_f <= RESET_PC;
`ifdef PC_EXC_EN
    else if (exc_take)  pc_f <= EXC_VEC;
    else if (eret_take) pc_f <= epc_q;
`endif
    else if (!stall)    pc_f <= npc;
  end

  // Saturating count of accepted redirects
  always_ff @(posedge clk) begin
    if (!reset)
      redirect_cnt <= '0;
    else if (accept && (redirect_cnt != '1))
      redirect_cnt <= redirect_cnt + 1'b1;
  end

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed-vector bench for pc_gen with a behavioural reference model.
// Two instances: default (delay slot, 16-bit counter) and no-delay-slot with a
// 2-bit counter. Exception tests compile in when PC_EXC_EN is defined.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [31:0] ir_d, pc4_d, rs_d, rt_d;

  logic [31:0] pc_f0, pc4_f0, pc_f1, pc4_f1;
  logic        redir0, redir1, kill0, kill1;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;

  logic        exc_req_s = 1'b0;
  logic [31:0] exc_pc_s  = '0;
  logic        eret_s    = 1'b0;
`ifdef PC_EXC_EN
  logic [31:0] epc0, epc1;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pc_gen #(.RESET_PC(32'h0000_3000), .DELAY_SLOT(1), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .stall(stall), .ir_d(ir_d), .pc4_d(pc4_d),
    .rs_d(rs_d), .rt_d(rt_d), .pc_f(pc_f0), .pc4_f(pc4_f0),
    .redirect(redir0), .kill_f(kill0), .redirect_cnt(cnt0)
`ifdef PC_EXC_EN
    , .exc_req(exc_req_s), .exc_pc(exc_pc_s), .eret(eret_s), .epc(epc0)
`endif
  );

  pc_gen #(.RESET_PC(32'h0000_3000), .DELAY_SLOT(0), .CNT_W(2)) dut1 (
    .clk(clk), .reset(reset), .stall(stall), .ir_d(ir_d), .pc4_d(pc4_d),
    .rs_d(rs_d), .rt_d(rt_d), .pc_f(pc_f1), .pc4_f(pc4_f1),
    .redirect(redir1), .kill_f(kill1), .redirect_cnt(cnt1)
`ifdef PC_EXC_EN
    , .exc_req(exc_req_s), .exc_pc(exc_pc_s), .eret(eret_s), .epc(epc1)
`endif
  );

  // ---------------- reference model ----------------
  logic [31:0] m_pc, m_epc;
  int unsigned m_cnt0, m_cnt1;
  bit          m_valid = 0;

  // Returns {taken, target} straight from the ISA rules
  function automatic logic [32:0] flow(input logic [31:0] ir, input logic [31:0] pc4,
                                       input logic [31:0] rs, input logic [31:0] rt);
    int          op, rtf, fn;
    int signed   srs;
    logic [31:0] btgt, jtgt, pcd;
    logic [31:0] off;
    op   = int'(ir >> 26);
    rtf  = int'((ir >> 16) & 32'h1f);
    fn   = int'(ir & 32'h3f);
    srs  = int'(signed'(rs));
    off  = ir[15] ? (32'hFFFF_0000 | (ir & 32'hFFFF)) : (ir & 32'hFFFF);
    btgt = pc4 + off * 4;
    pcd  = pc4 - 4;
    jtgt = (pcd & 32'hF000_0000) | ((ir & 32'h03FF_FFFF) * 4);
    case (op)
      4: return {rs == rt, btgt};
      5: return {rs != rt, btgt};
      6: return {srs <= 0, btgt};
      7: return {srs > 0, btgt};
      1: return {(rtf == 0 && srs < 0) || (rtf == 1 && srs >= 0), btgt};
      2, 3: return {1'b1, jtgt};
      0: return {(fn == 8 || fn == 9), rs};
      default: return {1'b0, 32'h0};
    endcase
  endfunction

  // Advance model state on each rising edge from the same inputs the DUTs see
  always @(posedge clk) begin
    logic [32:0] f;
    bit acc;
    f = flow(ir_d, pc4_d, rs_d, rt_d);
    if (!reset) begin
      m_pc = 32'h3000; m_cnt0 = 0; m_cnt1 = 0; m_epc = 0; m_valid = 1;
    end else begin
      acc = f[32] && !stall && !exc_req_s && !eret_s;
      if (exc_req_s) begin
        m_pc = 32'h4180; m_epc = exc_pc_s;
      end else if (eret_s) m_pc = m_epc;
      else if (!stall) m_pc = f[32] ? f[31:0] : m_pc + 4;
      if (acc) begin
        if (m_cnt0 < 65535) m_cnt0++;
        if (m_cnt1 < 3) m_cnt1++;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare both DUTs against the model away from the active edge
  always @(negedge clk) begin
    logic [32:0] f;
    bit acc;
    if (m_valid) begin
      f   = flow(ir_d, pc4_d, rs_d, rt_d);
      acc = f[32] && !stall && !exc_req_s && !eret_s;
      check("redirect0", {31'b0, redir0}, {31'b0, f[32]});
      check("redirect1", {31'b0, redir1}, {31'b0, f[32]});
      check("kill0", {31'b0, kill0}, 32'd0);
      check("kill1", {31'b0, kill1}, {31'b0, acc});
      check("pc_f0", pc_f0, m_pc);
      check("pc_f1", pc_f1, m_pc);
      check("pc4_f0", pc4_f0, m_pc + 4);
      check("pc4_f1", pc4_f1, m_pc + 4);
      check("cnt0", {16'b0, cnt0}, m_cnt0);
      check("cnt1", {30'b0, cnt1}, m_cnt1);
`ifdef PC_EXC_EN
      check("epc0", epc0, m_epc);
      check("epc1", epc1, m_epc);
`endif
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input logic [31:0] ir, input logic [31:0] pc4,
                       input logic [31:0] rs, input logic [31:0] rt, input logic st);
    ir_d = ir; pc4_d = pc4; rs_d = rs; rt_d = rt; stall = st;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] NOP = 32'h0000_0000;

  initial begin
    logic [31:0] held;
    reset = 1'b0;
    drive(NOP, 32'h0, 32'h0, 32'h0, 1'b0);
    #1;
    step(); step();
    check("lit_reset_pc", pc_f0, 32'h0000_3000);
    check("lit_reset_cnt", {16'b0, cnt0}, 32'd0);
    reset = 1'b1;
    step();
    check("lit_pc_after_reset", pc_f0, 32'h0000_3004);

    // beq taken backwards: 0x3008 + (-8) = 0x3000
    drive(32'h1022_FFFE, 32'h3008, 32'd5, 32'd5, 1'b0);
    #1;
    check("lit_beq_redirect", {31'b0, redir0}, 32'd1);
    check("lit_beq_kill1", {31'b0, kill1}, 32'd1);
    step();
    check("lit_beq_pc", pc_f0, 32'h0000_3000);
    check("lit_beq_cnt", {16'b0, cnt0}, 32'd1);
    // beq not taken
    drive(32'h1022_FFFE, 32'h3008, 32'd5, 32'd6, 1'b0);
    #1;
    check("lit_kill1_one_cycle", {31'b0, kill1}, 32'd0);
    step();
    check("lit_beq_nt_pc", pc_f0, 32'h0000_3004);

    // bltz taken, bgez taken, bgtz(0) falls through, REGIMM rt=2 not a branch
    drive(32'h0420_0004, 32'h3008, 32'h8000_0000, 32'h0, 1'b0); step();
    check("lit_bltz_pc", pc_f0, 32'h0000_3018);
    drive(32'h0421_0004, 32'h3008, 32'h0, 32'h0, 1'b0); step();
    drive(32'h1C20_0004, 32'h3008, 32'h0, 32'h0, 1'b0); step();
    drive(32'h0422_0004, 32'h3008, 32'h8000_0000, 32'h0, 1'b0); step();
    drive(32'h1820_0004, 32'h3008, 32'h0, 32'h0, 1'b0); step();          // blez 0
    drive(32'h1C20_0004, 32'h3008, 32'h7FFF_FFFF, 32'h0, 1'b0); step();  // bgtz max
    drive(32'h1422_0010, 32'h3008, 32'd1, 32'd2, 1'b0); step();          // bne taken

    // jal in region 1; j from pc_d=0x0FFF_FFFC uses region 0
    drive(32'h0C00_0100, 32'h1000_0004, 32'h0, 32'h0, 1'b0); step();
    check("lit_jal_pc", pc_f0, 32'h1000_0400);
    drive(32'h0800_0100, 32'h1000_0000, 32'h0, 32'h0, 1'b0); step();
    check("lit_j_region_pc", pc_f0, 32'h0000_0400);

    // jr under stall: hold for two cycles, then take
    held = pc_f0;
    drive(32'h0020_0008, 32'h3008, 32'h3abc, 32'h0, 1'b1); step(); step();
    check("lit_jr_stall_pc", pc_f0, held);
    stall = 1'b0; step();
    check("lit_jr_pc", pc_f0, 32'h0000_3abc);
    drive(32'h0020_0009, 32'h3008, 32'h3001, 32'h0, 1'b0); step();       // jalr unaligned
    check("lit_jalr_pc", pc_f0, 32'h0000_3001);
    drive(NOP, 32'h3008, 32'h0, 32'h0, 1'b0); step();

    // Saturation of the 2-bit counter
    for (int i = 0; i < 4; i++) begin
      drive(32'h0800_0C00, 32'h3008, 32'h0, 32'h0, 1'b0); step();
    end
    check("lit_cnt1_sat", {30'b0, cnt1}, 32'd3);
    drive(NOP, 32'h3008, 32'h0, 32'h0, 1'b0); step();

`ifdef PC_EXC_EN
    // exception during stall with a pending jump, then eret
    drive(32'h0800_0100, 32'h3008, 32'h0, 32'h0, 1'b1);
    exc_req_s = 1'b1; exc_pc_s = 32'h3010; step();
    exc_req_s = 1'b0;
    check("lit_exc_pc", pc_f0, 32'h0000_4180);
    check("lit_exc_epc", epc0, 32'h0000_3010);
    drive(NOP, 32'h3008, 32'h0, 32'h0, 1'b0); step(); step();
    eret_s = 1'b1; step();
    eret_s = 1'b0;
    check("lit_eret_pc", pc_f0, 32'h0000_3010);
    exc_req_s = 1'b1; eret_s = 1'b1; exc_pc_s = 32'h5000; step();
    exc_req_s = 1'b0; eret_s = 1'b0;
    check("lit_exc_eret_pc", pc_f0, 32'h0000_4180);
    step();
`endif

    // Reset during a taken jump and during a stall
    drive(32'h0C00_0100, 32'h1000_0004, 32'h0, 32'h0, 1'b0);
    reset = 1'b0; step();
    check("lit_rst_redir_pc", pc_f0, 32'h0000_3000);
    check("lit_rst_redir_pc4", pc4_f0, 32'h0000_3004);
    check("lit_rst_redir_cnt", {16'b0, cnt0}, 32'd0);
    reset = 1'b1;
    drive(NOP, 32'h3008, 32'h0, 32'h0, 1'b1); step();
    reset = 1'b0; step();
    check("lit_rst_stall_pc", pc_f0, 32'h0000_3000);
    reset = 1'b1;
    drive(NOP, 32'h3008, 32'h0, 32'h0, 1'b0); step(); step();

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Fetch-stage PC generator for the pipelined MIPS core. It owns the PC register and decodes all control-flow in the D-stage instruction. Branches resolve in D against forwarded operands: beq, bne, blez, bgtz, bltz, bgez, j, jal, jr, jalr. It supports delay-slot and no-delay-slot modes, stall hold, a saturating redirect counter and an optional exception/eret path.

Parameters:
RESET_PC, 32'h0000_3000, value loaded into pc_f on reset
DELAY_SLOT, 1, 1 = architectural delay slot (F instr kept); 0 = taken control-flow squashes the F instr
CNT_W, 16, width of redirect performance counter
EXC_VEC, 32'h0000_4180, exception handler entry (used only with PC_EXC_EN)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-low reset
stall  input  1  hazard stall; hold pc_f (D instr also held upstream)
ir_d  input  32  D-stage instruction
pc4_d  input  32  D-stage PC+4
rs_d  input  32  forwarded rs value (compare operand, jr/jalr target)
rt_d  input  32  forwarded rt value (beq/bne operand)
pc_f  output  32  current fetch PC (register)
pc4_f  output  32  pc_f+4
redirect  output  1  D instr is control-flow and taken this cycle
kill_f  output  1  squash F instr (DELAY_SLOT=0 only)
redirect_cnt  output  CNT_W  saturating count of accepted redirects

Behaviour:
- Decode (op=ir_d[31:26], rt=ir_d[20:16], func=ir_d[5:0]): beq 000100 (rs==rt); bne 000101 (rs!=rt); blez 000110 (signed rs<=0); bgtz 000111 (signed rs>0); REGIMM 000001 with rt=00000 bltz (rs<0), rt=00001 bgez (rs>=0); j 000010; jal 000011; op 000000 with func 001000 jr, 001001 jalr. Other REGIMM rt codes are not branches.
- Branch target = pc4_d + {{14{ir_d[15]}},ir_d[15:0],2'b00}, mod 2^32.
- Jump target = {pc_d[31:28], ir_d[25:0], 2'b00}, where pc_d = pc4_d-4. This matters when pc4_d crosses a 256 MB region.
- jr/jalr target = rs_d verbatim; no alignment check.
- redirect = taken branch or any jump; combinational from D inputs.
- npc = target when redirect, else pc_f+4.
- Register update, priority high to low: !reset -> pc_f=RESET_PC, redirect_cnt=0; exception/eret (optional feature); stall -> hold pc_f; else pc_f=npc.
- Redirect accepted = redirect & !stall. redirect_cnt increments on each accepted redirect and saturates at all-ones (no wrap).
- kill_f = (DELAY_SLOT==0) & redirect & !stall; constant 0 when DELAY_SLOT=1.
- Stall together with redirect: no redirect, no kill, no count. The redirect re-evaluates in the cycle stall drops.
- Reset mid-stall or mid-redirect: reset wins; all outputs reach reset values the following cycle. pc4_f = RESET_PC+4 after reset.

Optional Feature:
Macro PC_EXC_EN.
- When defined, adds ports: exc_req in 1, exc_pc in 32 (victim PC), eret in 1, epc out 32. Adds an internal EPC register, reset to 0.
- exc_req: pc_f=EXC_VEC and epc=exc_pc. Overrides stall and redirect. No count, no kill.
- eret (when not exc_req): pc_f=epc. Overrides stall.
- exc_req and eret together: exc_req wins and epc updates.
- When undefined: no extra ports, no EPC register; behaviour is exactly as above.

Decomposition:
- Shared package: opcode/func/REGIMM-rt constants (OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_REGIMM, OP_J, OP_JAL, FN_JR, FN_JALR, RT_BLTZ, RT_BGEZ), plus default RESET_PC/EXC_VEC.
- One sub-module is natural: branch_cmp, purely combinational. It takes op, rt field, rs_d and rt_d and produces taken. pc_gen holds all state and target muxing.

Test Plan:
- Reset low for 2 cycles, then high -> pc_f=0x3000, redirect_cnt=0; next cycle pc_f=0x3004.
- beq with rs_d=rt_d=5, pc4_d=0x3008, imm=0xFFFE -> redirect=1, next pc_f=0x3000, redirect_cnt=1. Same with rt_d=6 -> pc_f=prev+4.
- bltz rs_d=0x8000_0000, then bgez rs_d=0; bgtz rs_d=0 -> first two redirect, bgtz falls through.
- jal ir_d=0x0C00_0100 with pc4_d=0x1000_0004 -> pc_f=0x1000_0400. jr rs_d=0x3abc with stall=1 for 2 cycles -> pc_f held, cnt unchanged; after release pc_f=0x3abc.
- DELAY_SLOT=0, taken bne -> kill_f=1 for exactly one cycle. DELAY_SLOT=1 -> kill_f always 0. Preload counter to max via CNT_W=2 and 4 redirects -> stays 3.
- PC_EXC_EN: exc_req with exc_pc=0x3010 during stall -> pc_f=0x4180, epc=0x3010. Later eret -> pc_f=0x3010.
